// File: rtl/qsm_dim_master.sv
// QSPI master for one DIM daisy-chain line.
// Shifts a 16-bit word out of every device for every register address,
// writes each word into the readout SRAM and reports chain status.
module qsm_dim_master #(
    parameter int CLK_PER_US = 40,
    parameter int SCK_HALF   = 20,
    parameter int RESET_US   = 100,
    parameter int TRIG_US    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ctrl_reset_i,
    input  logic        ctrl_trig_i,
    input  logic [3:0]  ctrl_last_reg_adr_i,
    input  logic [3:0]  ctrl_max_dim_no_i,
    input  logic [9:0]  ctrl_read_delay_i,
    output logic        status_busy_o,
    output logic        status_done_o,
    output logic        status_err_many_o,
    output logic        status_err_fb_o,
    output logic [3:0]  status_dim_count_o,
    output logic        mem_we_o,
    output logic [6:0]  mem_addr_o,
    output logic [15:0] mem_data_o,
    output logic        qspi_clk_o,
    output logic        qspi_trig_o,
    output logic        qspi_rst_o,
    input  logic        qspi_data_i,
    input  logic        qspi_fb_i
);

    localparam int US_W   = $clog2(CLK_PER_US);
    localparam int CYC_W  = $clog2(SCK_HALF + 1);
    localparam int TICK_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        TRIG,
        SHIFT_LO,
        SHIFT_HI,
        WORD_END,
        DELAY
    } state_e;

    state_e              state_q, state_d;
    logic [US_W-1:0]     usCnt_q;
    logic                usTick;
    logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
    logic [CYC_W-1:0]    cycCnt_q, cycCnt_d;
    logic [3:0]          bitIdx_q, bitIdx_d;
    logic [2:0]          dev_q, dev_d;
    logic [3:0]          regAdr_q, regAdr_d;
    logic [15:0]         word_q, word_d;
    logic                fbBit_q, fbBit_d;
    logic [3:0]          lastReg_q, lastReg_d;
    logic [3:0]          maxDim_q, maxDim_d;
    logic [9:0]          readDelay_q, readDelay_d;
    logic                done_q, done_d;
    logic                errMany_q, errMany_d;
    logic                errFb_q, errFb_d;
    logic [3:0]          dimCount_q, dimCount_d;
    logic [3:0]          maxEff;
    logic [3:0]          devCount;

    assign usTick   = (usCnt_q == US_W'(CLK_PER_US - 1));
    assign maxEff   = ((ctrl_max_dim_no_i == 4'd0) || (ctrl_max_dim_no_i > 4'd8)) ? 4'd8 : ctrl_max_dim_no_i;
    assign devCount = {1'b0, dev_q} + 4'd1;

    // Free-running microsecond prescaler; every microsecond wait counts its wrap pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            usCnt_q <= '0;
        end else if (usTick) begin
            usCnt_q <= '0;
        end else begin
            usCnt_q <= usCnt_q + 1'b1;
        end
    end

    // State and datapath registers for the shift engine.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            cycCnt_q    <= '0;
            bitIdx_q    <= '0;
            dev_q       <= '0;
            regAdr_q    <= '0;
            word_q      <= '0;
            fbBit_q     <= 1'b0;
            lastReg_q   <= '0;
            maxDim_q    <= '0;
            readDelay_q <= '0;
            done_q      <= 1'b0;
            errMany_q   <= 1'b0;
            errFb_q     <= 1'b0;
            dimCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            cycCnt_q    <= cycCnt_d;
            bitIdx_q    <= bitIdx_d;
            dev_q       <= dev_d;
            regAdr_q    <= regAdr_d;
            word_q      <= word_d;
            fbBit_q     <= fbBit_d;
            lastReg_q   <= lastReg_d;
            maxDim_q    <= maxDim_d;
            readDelay_q <= readDelay_d;
            done_q      <= done_d;
            errMany_q   <= errMany_d;
            errFb_q     <= errFb_d;
            dimCount_q  <= dimCount_d;
        end
    end

    // Next-state logic: command handling, shift sequencing and end-of-word decisions.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        cycCnt_d    = cycCnt_q;
        bitIdx_d    = bitIdx_q;
        dev_d       = dev_q;
        regAdr_d    = regAdr_q;
        word_d      = word_q;
        fbBit_d     = fbBit_q;
        lastReg_d   = lastReg_q;
        maxDim_d    = maxDim_q;
        readDelay_d = readDelay_q;
        done_d      = done_q;
        errMany_d   = errMany_q;
        errFb_d     = errFb_q;
        dimCount_d  = dimCount_q;

        case (state_q)
            IDLE: begin
                if (ctrl_reset_i) begin
                    state_d   = RST_HOLD;
                    tickCnt_d = '0;
                end else if (ctrl_trig_i) begin
                    state_d     = TRIG;
                    tickCnt_d   = '0;
                    lastReg_d   = ctrl_last_reg_adr_i;
                    maxDim_d    = maxEff;
                    readDelay_d = ctrl_read_delay_i;
                    regAdr_d    = '0;
                    done_d      = 1'b0;
                    errMany_d   = 1'b0;
                    errFb_d     = 1'b0;
                end
            end
            RST_HOLD: begin
                if (usTick) begin
                    if (tickCnt_q == TICK_W'(RESET_US - 1)) begin
                        state_d   = IDLE;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end
            TRIG: begin
                if (usTick) begin
                    if (tickCnt_q == TICK_W'(TRIG_US - 1)) begin
                        state_d   = SHIFT_LO;
                        tickCnt_d = '0;
                        cycCnt_d  = '0;
                        dev_d     = '0;
                        bitIdx_d  = 4'd15;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                if (cycCnt_q == CYC_W'(SCK_HALF - 1)) begin
                    state_d  = SHIFT_HI;
                    cycCnt_d = '0;
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (cycCnt_q == '0) begin
                    word_d[bitIdx_q] = qspi_data_i;
                    fbBit_d          = qspi_fb_i;
                end
                if ((cycCnt_q == '0) && (bitIdx_q == 4'd15) && qspi_fb_i) begin
                    errFb_d  = 1'b1;
                    state_d  = IDLE;
                    cycCnt_d = '0;
                end else if (cycCnt_q == CYC_W'(SCK_HALF - 1)) begin
                    cycCnt_d = '0;
                    if (bitIdx_q != 4'd0) begin
                        bitIdx_d = bitIdx_q - 4'd1;
                        state_d  = SHIFT_LO;
                    end else begin
                        state_d = WORD_END;
                    end
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            WORD_END: begin
                if (fbBit_q) begin
                    if ((regAdr_q != 4'd0) && (devCount != dimCount_q)) begin
                        errFb_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dimCount_d = devCount;
                        if (regAdr_q == lastReg_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            regAdr_d  = regAdr_q + 4'd1;
                            tickCnt_d = '0;
                            state_d   = DELAY;
                        end
                    end
                end else if (devCount == maxDim_q) begin
                    errMany_d  = 1'b1;
                    dimCount_d = maxDim_q;
                    state_d    = IDLE;
                end else begin
                    dev_d    = dev_q + 3'd1;
                    bitIdx_d = 4'd15;
                    cycCnt_d = '0;
                    state_d  = SHIFT_LO;
                end
            end
            DELAY: begin
                if (readDelay_q == 10'd0) begin
                    state_d   = TRIG;
                    tickCnt_d = '0;
                end else if (usTick) begin
                    if ((tickCnt_q + 1'b1) == {6'd0, readDelay_q}) begin
                        state_d   = TRIG;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ctrl_reset_i && (state_q != IDLE) && (state_q != RST_HOLD)) begin
            state_d   = RST_HOLD;
            tickCnt_d = '0;
            cycCnt_d  = '0;
            done_d    = 1'b0;
        end
    end

    assign status_busy_o      = (state_q != IDLE);
    assign status_done_o      = done_q;
    assign status_err_many_o  = errMany_q;
    assign status_err_fb_o    = errFb_q;
    assign status_dim_count_o = dimCount_q;
    assign mem_we_o           = (state_q == WORD_END);
    assign mem_addr_o         = {dev_q, regAdr_q};
    assign mem_data_o         = word_q;
    assign qspi_clk_o         = (state_q == SHIFT_HI);
    assign qspi_trig_o        = (state_q == TRIG);
    assign qspi_rst_o         = (state_q == RST_HOLD);

endmodule

// File: tb/tb_qsm_dim_master.sv
// Directed bench for qsm_dim_master with a behavioural DIM chain model.
module tb_qsm_dim_master;

    localparam int CLK_PER_US = 4;
    localparam int SCK_HALF   = 2;
    localparam int RESET_US   = 5;
    localparam int TRIG_US    = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ctrl_reset_i = 1'b0;
    logic        ctrl_trig_i = 1'b0;
    logic [3:0]  ctrl_last_reg_adr_i = '0;
    logic [3:0]  ctrl_max_dim_no_i = '0;
    logic [9:0]  ctrl_read_delay_i = '0;
    logic        status_busy_o;
    logic        status_done_o;
    logic        status_err_many_o;
    logic        status_err_fb_o;
    logic [3:0]  status_dim_count_o;
    logic        mem_we_o;
    logic [6:0]  mem_addr_o;
    logic [15:0] mem_data_o;
    logic        qspi_clk_o;
    logic        qspi_trig_o;
    logic        qspi_rst_o;
    logic        qspiData;
    logic        qspiFb;

    int total = 0;
    int bad = 0;

    int nDev = 3;
    int fbMode = 0;
    logic modelClr = 1'b0;
    int mReg = -1;
    int mDev = 0;
    int mBit = 15;

    logic [6:0]  wrAddrQ[$];
    logic [15:0] wrDataQ[$];

    logic [34:0] outVec;
    assign outVec = {status_busy_o, status_done_o, status_err_many_o, status_err_fb_o,
                     status_dim_count_o, mem_we_o, mem_addr_o, mem_data_o,
                     qspi_clk_o, qspi_trig_o, qspi_rst_o};

    qsm_dim_master #(
        .CLK_PER_US(CLK_PER_US),
        .SCK_HALF  (SCK_HALF),
        .RESET_US  (RESET_US),
        .TRIG_US   (TRIG_US)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ctrl_reset_i       (ctrl_reset_i),
        .ctrl_trig_i        (ctrl_trig_i),
        .ctrl_last_reg_adr_i(ctrl_last_reg_adr_i),
        .ctrl_max_dim_no_i  (ctrl_max_dim_no_i),
        .ctrl_read_delay_i  (ctrl_read_delay_i),
        .status_busy_o      (status_busy_o),
        .status_done_o      (status_done_o),
        .status_err_many_o  (status_err_many_o),
        .status_err_fb_o    (status_err_fb_o),
        .status_dim_count_o (status_dim_count_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_data_o         (mem_data_o),
        .qspi_clk_o         (qspi_clk_o),
        .qspi_trig_o        (qspi_trig_o),
        .qspi_rst_o         (qspi_rst_o),
        .qspi_data_i        (qspiData),
        .qspi_fb_i          (qspiFb)
    );

    // Free-running system clock.
    always #5 clk_i = ~clk_i;

    // Each device returns 0xA<dev><reg>5 for every register.
    function automatic logic [15:0] wordFor(input int d, input int r);
        logic [3:0] dn;
        logic [3:0] rn;
        dn = d[3:0];
        rn = r[3:0];
        return {4'hA, dn, rn, 4'h5};
    endfunction

    // Chain position tracker: a trigger restarts at device 0 bit 15, each falling shift clock moves one bit on.
    always @(posedge modelClr or posedge qspi_trig_o or negedge qspi_clk_o) begin
        if (modelClr) begin
            mReg = -1;
            mDev = 0;
            mBit = 15;
        end else if (qspi_trig_o) begin
            mReg = mReg + 1;
            mDev = 0;
            mBit = 15;
        end else if (mBit == 0) begin
            mBit = 15;
            mDev = mDev + 1;
        end else begin
            mBit = mBit - 1;
        end
    end

    // Serial data and feedback presented by the modelled chain.
    always_comb begin
        logic [15:0] w;
        w = '0;
        qspiData = 1'b0;
        qspiFb = 1'b0;
        if (mReg >= 0 && mDev < nDev) begin
            w = wordFor(mDev, mReg);
            qspiData = w[mBit];
        end
        if (fbMode == 0) begin
            qspiFb = (mDev == nDev - 1) && (mBit == 0);
        end else begin
            qspiFb = (mReg >= 0) && (mDev == 0) && (mBit == 15);
        end
    end

    // Record every SRAM write the DUT makes.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            wrAddrQ.push_back(mem_addr_o);
            wrDataQ.push_back(mem_data_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstPulse, input logic trigPulse,
                                 input logic [3:0] lastReg, input logic [3:0] maxDim,
                                 input logic [9:0] delay);
        @(negedge clk_i);
        ctrl_reset_i        = rstPulse;
        ctrl_trig_i         = trigPulse;
        ctrl_last_reg_adr_i = lastReg;
        ctrl_max_dim_no_i   = maxDim;
        ctrl_read_delay_i   = delay;
        @(negedge clk_i);
        ctrl_reset_i = 1'b0;
        ctrl_trig_i  = 1'b0;
    endtask

    task automatic clearModel();
        modelClr = 1'b1;
        #1;
        modelClr = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (status_busy_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("idleReached", {63'd0, status_busy_o}, 64'd0);
    endtask

    task automatic waitSck(input int budget);
        int n;
        n = 0;
        while (!qspi_clk_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("sckSeen", {63'd0, qspi_clk_o}, 64'd1);
    endtask

    task automatic checkWrites(input int start, input int nRegs, input int devs);
        int idx;
        checkOutput("wrCount", 64'(wrAddrQ.size() - start), 64'(nRegs * devs));
        for (int r = 0; r < nRegs; r++) begin
            for (int d = 0; d < devs; d++) begin
                idx = start + r * devs + d;
                if (idx < wrAddrQ.size()) begin
                    checkOutput($sformatf("wrAddr%0d", idx - start), {57'd0, wrAddrQ[idx]}, {57'd0, d[2:0], r[3:0]});
                    checkOutput($sformatf("wrData%0d", idx - start), {48'd0, wrDataQ[idx]}, {48'd0, wordFor(d, r)});
                end
            end
        end
    endtask

    initial begin
        int start;
        int rstLen;
        int busyBad;

        // Power-on reset.
        repeat (3) @(negedge clk_i);
        checkOutput("resetOuts", {29'd0, outVec}, 64'd0);
        rst_i = 1'b0;

        // Three devices, registers 0..1.
        clearModel();
        nDev = 3;
        fbMode = 0;
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd4, 10'd3);
        checkOutput("busyAfterTrig", {63'd0, status_busy_o}, 64'd1);
        waitIdle(3000);
        checkWrites(start, 2, 3);
        checkOutput("flagsNormal", {57'd0, status_done_o, status_err_many_o, status_err_fb_o, status_dim_count_o},
                    {57'd0, 3'b100, 4'd3});

        // Chain longer than the configured maximum.
        clearModel();
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd2, 10'd3);
        waitIdle(3000);
        checkWrites(start, 1, 2);
        checkOutput("flagsMany", {57'd0, status_done_o, status_err_many_o, status_err_fb_o, status_dim_count_o},
                    {57'd0, 3'b010, 4'd2});

        // Feedback already high at bit 15 of device 0.
        clearModel();
        fbMode = 1;
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd4, 10'd3);
        waitIdle(3000);
        checkWrites(start, 0, 3);
        checkOutput("flagsFb", {61'd0, status_done_o, status_err_many_o, status_err_fb_o}, {61'd0, 3'b001});
        fbMode = 0;

        // Reset command from idle: 5 ticks of 4 cycles, first tick possibly short.
        clearModel();
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd4, 10'd3);
        rstLen = 0;
        busyBad = 0;
        while (qspi_rst_o && rstLen < 100) begin
            if (!status_busy_o) busyBad++;
            rstLen++;
            @(negedge clk_i);
        end
        checkOutput("rstLenInRange", {63'd0, (rstLen >= 17 && rstLen <= 20)}, 64'd1);
        checkOutput("busyDuringRst", 64'(busyBad), 64'd0);
        checkOutput("busyAfterRst", {63'd0, status_busy_o}, 64'd0);
        checkOutput("flagsKeptOverRst", {61'd0, status_done_o, status_err_many_o, status_err_fb_o}, {61'd0, 3'b001});

        // Reset command while the shift clock is high on register 0.
        clearModel();
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd4, 10'd3);
        waitSck(500);
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd4, 10'd3);
        checkOutput("abortPins", {61'd0, qspi_clk_o, qspi_rst_o, status_busy_o}, {61'd0, 3'b011});
        waitIdle(3000);
        checkWrites(start, 0, 3);
        checkOutput("abortDone", {63'd0, status_done_o}, 64'd0);

        // Reset and trigger in the same idle cycle.
        clearModel();
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd4, 10'd3);
        checkOutput("bothPins", {62'd0, qspi_trig_o, qspi_rst_o}, {62'd0, 2'b01});
        waitIdle(3000);
        checkOutput("bothNoScan", 64'(mReg + 1), 64'd0);

        // A second trigger during a readout must not restart it.
        clearModel();
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd4, 10'd3);
        waitSck(500);
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd1, 10'd0);
        waitIdle(3000);
        checkWrites(start, 2, 3);
        checkOutput("flagsBusyTrig", {57'd0, status_done_o, status_err_many_o, status_err_fb_o, status_dim_count_o},
                    {57'd0, 3'b100, 4'd3});

        // Synchronous reset in the middle of a shift, then a fresh readout.
        clearModel();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd4, 10'd3);
        waitSck(500);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("midShiftReset", {29'd0, outVec}, 64'd0);
        rst_i = 1'b0;
        clearModel();
        start = wrAddrQ.size();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd0, 10'd0);
        waitIdle(3000);
        checkWrites(start, 2, 3);
        checkOutput("flagsAfterRst", {57'd0, status_done_o, status_err_many_o, status_err_fb_o, status_dim_count_o},
                    {57'd0, 3'b100, 4'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
